// File: rtl/display_pager.sv
// Pages a captured AES block onto the 4-digit display driver one 16-bit word at a time,
// advancing on a synchronized "next" button edge or an auto-advance dwell timer.
module display_pager #(
  parameter int WORDS        = 8,
  parameter int DWELL_CYCLES = 100000000
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [0:16*WORDS-1]      i_block,
  input  logic                     i_block_valid,
  input  logic                     i_next,
  input  logic                     i_auto,
  output logic [0:15]              o_data,
  output logic                     o_refresh_display,
  output logic [$clog2(WORDS)-1:0] o_page,
  output logic                     o_loaded
);

  localparam int PW = $clog2(WORDS);
  localparam int CW = $clog2(DWELL_CYCLES + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [PW-1:0] PAGE_LAST  = PW'(WORDS - 1);

  typedef enum logic [1:0] {S_EMPTY, S_PRESENT, S_HOLD} state_t;

  state_t              r_state, w_state_next;
  logic [0:16*WORDS-1] r_block;
  logic [PW-1:0]       r_page, w_page_next, w_opage_next;
  logic [CW-1:0]       r_dwell, w_dwell_next;
  logic                r_sync1, r_sync2, r_edge;
  logic                w_next_evt, w_dwell_done, w_capture, w_show;
  logic [0:15]         w_word, w_data_next;

  assign w_next_evt   = r_sync2 & ~r_edge;
  assign w_dwell_done = i_auto && (r_dwell == DWELL_LAST);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_sync1 <= i_next;
      r_sync2 <= r_sync1;
      r_edge  <= r_sync2;
    end
  end

  always_comb begin
    w_word = r_block[0:15];
    for (int k = 1; k < WORDS; k++)
      if (r_page == PW'(k)) w_word = r_block[16*k +: 16];
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_state <= S_EMPTY;
    else      r_state <= w_state_next;
  end

  // A new block always wins; a button edge or dwell expiry coinciding with it is dropped.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_page_next  = r_page;
    case (r_state)
      S_EMPTY: begin
        if (i_block_valid) begin
          w_capture    = 1'b1;
          w_page_next  = '0;
          w_state_next = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (i_block_valid) begin
          w_capture   = 1'b1;
          w_page_next = '0;
        end else begin
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (i_block_valid) begin
          w_capture    = 1'b1;
          w_page_next  = '0;
          w_state_next = S_PRESENT;
        end else if (w_next_evt || w_dwell_done) begin
          w_page_next  = (r_page == PAGE_LAST) ? '0 : r_page + 1'b1;
          w_state_next = S_PRESENT;
        end
      end
      default: w_state_next = S_EMPTY;
    endcase
  end

  // A PRESENT cycle interrupted by a recapture shows nothing; the repeated PRESENT shows word 0.
  always_comb begin
    w_show       = (r_state == S_PRESENT) && !i_block_valid;
    w_data_next  = o_data;
    w_opage_next = o_page;
    w_dwell_next = r_dwell;
    if (w_show) begin
      w_data_next  = w_word;
      w_opage_next = r_page;
      w_dwell_next = '0;
    end else if (r_state == S_HOLD) begin
      w_dwell_next = i_auto ? r_dwell + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_block           <= '0;
      r_page            <= '0;
      r_dwell           <= '0;
      o_data            <= '0;
      o_refresh_display <= 1'b0;
      o_page            <= '0;
      o_loaded          <= 1'b0;
    end else begin
      if (w_capture) begin
        r_block  <= i_block;
        o_loaded <= 1'b1;
      end
      r_page            <= w_page_next;
      r_dwell           <= w_dwell_next;
      o_data            <= w_data_next;
      o_refresh_display <= w_show;
      o_page            <= w_opage_next;
    end
  end

endmodule
